// File: rtl/buff_mem_xfer.sv
// rtl/buff_mem_xfer.sv - word transfer engine between the internal buffer and data memory
//
// Moves offset+1 words between a small internal buffer and the data-memory port.
// dir=0 stores buffer->memory, dir=1 loads memory->buffer. Each word takes a read
// cycle (RD) followed by a write cycle (WR). Both RAMs return read data one cycle after
// the read strobe.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, abort, dir    transfer request, cancel, direction
//   addr_data_mem        data-memory base byte address
//   addr_buff            buffer base index
//   offset               last word index (count = offset+1), must be < 2**BUF_AW
//   buf_re/we/addr/wdata buffer port (buf_rdata returned one cycle after buf_re)
//   mem_re/we/addr/wdata data-memory port (mem_rdata returned one cycle after mem_re)
//   busy                 high in RD/WR/DONE
//   done                 one-cycle pulse when a transfer completes
//   err                  one-cycle pulse when a request is rejected for a bad offset
module buff_mem_xfer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BUF_AW = 4,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              dir,
    input  logic [ADDR_W-1:0] addr_data_mem,
    input  logic [BUF_AW-1:0] addr_buff,
    input  logic [31:0]       offset,
    output logic              buf_re,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_AW-1:0] idx_q, idx_d;
    logic [BUF_AW-1:0] last_q, last_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] mem_base_q, mem_base_d;
    logic [BUF_AW-1:0] buf_base_q, buf_base_d;

    logic              buf_re_d, buf_we_d, mem_re_d, mem_we_d;
    logic              busy_d, done_d, err_d;
    logic [BUF_AW-1:0] buf_addr_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              in_rd, in_wr;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        dir_d      = dir_q;
        mem_base_d = mem_base_q;
        buf_base_d = buf_base_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has priority over start; an out-of-range offset is rejected
                // without disturbing the latched request fields.
                if (start && !abort) begin
                    if (offset[31:BUF_AW] != '0) begin
                        err_d = 1'b1;
                    end else begin
                        dir_d      = dir;
                        mem_base_d = addr_data_mem;
                        buf_base_d = addr_buff;
                        last_d     = offset[BUF_AW-1:0];
                        idx_d      = '0;
                        state_d    = S_RD;
                    end
                end
            end
            S_RD: begin
                // aborting here drops the word whose read is in flight
                state_d = abort ? S_IDLE : S_WR;
            end
            S_WR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + BUF_AW'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output registers are loaded from the next state so strobes line up with
        // the state they belong to.
        in_rd      = (state_d == S_RD);
        in_wr      = (state_d == S_WR);
        buf_re_d   = in_rd && !dir_d;
        mem_re_d   = in_rd && dir_d;
        mem_we_d   = in_wr && !dir_d;
        buf_we_d   = in_wr && dir_d;
        buf_addr_d = (buf_re_d || buf_we_d) ? (buf_base_d + idx_d) : '0;
        mem_addr_d = (mem_re_d || mem_we_d)
                   ? (mem_base_d + ADDR_W'(STRIDE) * ADDR_W'(idx_d)) : '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            dir_q      <= 1'b0;
            mem_base_q <= '0;
            buf_base_q <= '0;
            buf_re     <= 1'b0;
            buf_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            buf_addr   <= '0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            dir_q      <= dir_d;
            mem_base_q <= mem_base_d;
            buf_base_q <= buf_base_d;
            buf_re     <= buf_re_d;
            buf_we     <= buf_we_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            buf_addr   <= buf_addr_d;
            mem_addr   <= mem_addr_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Read data only becomes valid in the WR cycle itself, so write data is the
    // source RAM's registered output passed through, gated by the registered strobe.
    assign mem_wdata = mem_we ? buf_rdata : '0;
    assign buf_wdata = buf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_buff_mem_xfer.sv
// tb/tb_buff_mem_xfer.sv - scoreboard bench for buff_mem_xfer
module tb_buff_mem_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, dir;
    logic [31:0] addr_data_mem;
    logic [3:0]  addr_buff;
    logic [31:0] offset;
    logic        buf_re, buf_we, mem_re, mem_we;
    logic [3:0]  buf_addr;
    logic [31:0] buf_wdata, buf_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, err;

    buff_mem_xfer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dir(dir),
        .addr_data_mem(addr_data_mem), .addr_buff(addr_buff), .offset(offset),
        .buf_re(buf_re), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          to_mem;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, err_cnt = 0, re_cnt = 0, mwr_cnt = 0, last_done_cyc = 0;

    logic [31:0] buf_mem [16];

    function automatic logic [31:0] buf_init(input int i);
        return 32'hB000_0000 | (32'(i) * 32'h11);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hD000_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer RAM model, re-seeded with a known pattern on reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) buf_mem[i] <= buf_init(i);
            buf_rdata <= '0;
        end else begin
            if (buf_we) buf_mem[buf_addr] <= buf_wdata;
            if (buf_re) buf_rdata <= buf_mem[buf_addr];
        end
    end

    // Data memory read model: content is a fixed function of the address.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_word(mem_addr);
        else        mem_rdata <= '0;
    end

    task automatic sb_check(input bit to_mem, input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        chk("wr_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_kind", 64'(to_mem), 64'(e.to_mem));
            chk("wr_addr", 64'(a), 64'(e.addr));
            chk("wr_data", 64'(d), 64'(e.data));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (err) err_cnt++;
            if (buf_re || mem_re) re_cnt++;
            if (mem_we) begin mwr_cnt++; sb_check(1'b1, mem_addr, mem_wdata); end
            if (buf_we) sb_check(1'b0, {28'b0, buf_addr}, buf_wdata);
        end
    end

    task automatic push_words(input bit d, input logic [31:0] mb, input logic [3:0] ab, input int n);
        wr_t e;
        logic [3:0] bi;
        for (int i = 0; i < n; i++) begin
            bi = ab + 4'(i);
            e.to_mem = !d;
            if (!d) begin
                e.addr = mb + 32'(4 * i);
                e.data = buf_init(int'(bi));
            end else begin
                e.addr = {28'b0, bi};
                e.data = mem_word(mb + 32'(4 * i));
            end
            sb.push_back(e);
        end
    endtask

    task automatic drive_start(input bit d, input logic [31:0] mb, input logic [3:0] ab, input int off);
        @(posedge clk); #1;
        dir = d; addr_data_mem = mb; addr_buff = ab; offset = 32'(off); start = 1'b1;
    endtask

    task automatic run_xfer(input bit d, input logic [31:0] mb, input logic [3:0] ab,
                            input int off, input bit poke);
        int t0, n0;
        push_words(d, mb, ab, off + 1);
        n0 = done_cnt;
        drive_start(d, mb, ab, off);
        t0 = cyc;
        @(posedge clk); #1; start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (poke) begin
            // start while busy must be ignored and must not disturb latched fields
            start = 1'b1; addr_data_mem = 32'hDEAD_0000; addr_buff = ab + 4'd5;
            offset = 32'd0; dir = !d;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int k = 0; k < 100 && done_cnt == n0; k++) begin
            @(posedge clk); #1;
        end
        chk("done_count", 64'(done_cnt - n0), 64'd1);
        chk("done_latency", 64'(last_done_cyc - t0), 64'(2 * (off + 1) + 1));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        chk("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int n0, r0, m0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
        addr_data_mem = '0; addr_buff = '0; offset = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_outputs", 64'(|{buf_re, buf_we, buf_addr, buf_wdata, mem_re, mem_we,
                                   mem_addr, mem_wdata, busy, done, err}), 64'd0);

        // store 3 words from buf[2..4] with a stray start poked mid-transfer
        run_xfer(1'b0, 32'h100, 4'd2, 2, 1'b1);
        // single-word store
        run_xfer(1'b0, 32'h180, 4'd7, 0, 1'b0);

        // reject offset = depth
        n0 = err_cnt; r0 = re_cnt;
        drive_start(1'b0, 32'h0, 4'd0, 16);
        @(posedge clk); #1; start = 1'b0;
        chk("reject_err", 64'(err), 64'd1);
        chk("reject_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk); #1;
        chk("reject_err_once", 64'(err_cnt - n0), 64'd1);
        chk("reject_no_strobe", 64'(re_cnt - r0), 64'd0);

        // abort at the second RD of a 4-word store
        push_words(1'b0, 32'h300, 4'd8, 1);
        n0 = done_cnt; m0 = mwr_cnt;
        drive_start(1'b0, 32'h300, 4'd8, 3);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_rd_addr", 64'({buf_re, buf_addr}), 64'({1'b1, 4'd9}));
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_idle", 64'({busy, buf_re, mem_we}), 64'd0);
        repeat (8) @(posedge clk); #1;
        chk("abort_no_done", 64'(done_cnt - n0), 64'd0);
        chk("abort_one_write", 64'(mwr_cnt - m0), 64'd1);
        chk("abort_sb", 64'(sb.size()), 64'd0);

        // load with buffer index wrap 14,15,0,1
        run_xfer(1'b1, 32'h200, 4'd14, 3, 1'b0);

        // reset during the first WR of a load
        push_words(1'b1, 32'h400, 4'd4, 1);
        n0 = done_cnt;
        drive_start(1'b1, 32'h400, 4'd4, 3);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("wr_before_reset", 64'(buf_we), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("reset_mid_outputs", 64'(|{buf_re, buf_we, buf_addr, buf_wdata, mem_re, mem_we,
                                       mem_addr, mem_wdata, busy, done, err}), 64'd0);
        repeat (6) @(posedge clk); #1;
        chk("reset_no_done", 64'(done_cnt - n0), 64'd0);
        chk("reset_sb", 64'(sb.size()), 64'd0);

        // normal transfer after reset
        run_xfer(1'b0, 32'h500, 4'd0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
